// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP microcode sequencer: instruction layout,
// opcodes and the sequencer state encoding.
package dsp_seq_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 13;
  localparam int SEL_LSB     = 0;
  localparam int SEL_WIDTH   = 4;
  localparam int PTR_LSB     = 4;
  localparam int INC_BIT     = 8;
  localparam int SRST_BIT    = 9;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_EXEC       = 3'd1;
  localparam logic [2:0] OP_LOOP_BEGIN = 3'd2;
  localparam logic [2:0] OP_LOOP_END   = 3'd3;
  localparam logic [2:0] OP_WAIT       = 3'd4;
  localparam logic [2:0] OP_END        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN,
    ST_STALL,
    ST_BUBBLE
  } state_e;

endpackage

// File: rtl/dsp_sequencer_if.sv
// Bundle of the sequencer's run control, program-memory port and
// address-generator command outputs.
interface dsp_sequencer_if #(
  parameter int PC_WIDTH     = 6,
  parameter int OFFSET_WIDTH = 4
);
  logic                               start;
  logic                               busy;
  logic                               done;
  logic                               err;
  logic [PC_WIDTH-1:0]                prog_addr;
  logic [dsp_seq_pkg::INSTR_WIDTH-1:0] prog_data;
  logic [3:0]                         addr_sel;
  logic [OFFSET_WIDTH-1:0]            addr_ptr;
  logic                               series_inc;
  logic                               series_rst;
  logic                               addr_valid;

  modport master (
    input  start, prog_data,
    output busy, done, err, prog_addr, addr_sel, addr_ptr,
           series_inc, series_rst, addr_valid
  );

  modport slave (
    output start, prog_data,
    input  busy, done, err, prog_addr, addr_sel, addr_ptr,
           series_inc, series_rst, addr_valid
  );
endinterface

// File: rtl/pipeline_delay.sv
// Fixed-latency delay line. With SHIFT_MEM set the stages carry no reset so
// they can map onto shift-register primitives.
module pipeline_delay #(
  parameter int WIDTH     = 1,
  parameter int CYCLES    = 1,
  parameter int SHIFT_MEM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage_q [CYCLES];

  always_ff @(posedge clk) begin
    if (rst && (SHIFT_MEM == 0)) begin
      for (int i = 0; i < CYCLES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < CYCLES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[CYCLES-1];
endmodule

// File: rtl/dsp_sequencer.sv
// Microcode sequencer driving the DSP address generator from a program held
// in synchronous memory; one counted loop level, waits and END termination.
//   state     | meaning
//   ST_IDLE   | waiting for start; outputs zero
//   ST_FETCH  | first program word in flight
//   ST_RUN    | decoding prog_data, one instruction per cycle
//   ST_STALL  | WAIT countdown, fetch address held
//   ST_BUBBLE | discarding the word fetched behind a taken LOOP_END
module dsp_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int PC_WIDTH     = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int LOOP_WIDTH   = 8,
  parameter int ADDR_LAT     = 3
) (
  input logic             clk,
  input logic             rst,
  dsp_sequencer_if.master bus
);
  localparam logic [PC_WIDTH-1:0] PC_LAST = '1;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     prog_addr_q, prog_addr_d, ir_pc_q;
  logic [PC_WIDTH-1:0]     loop_start_q, loop_start_d;
  logic                    loop_active_q, loop_active_d;
  logic [LOOP_WIDTH-1:0]   loop_cnt_q, loop_cnt_d, wait_cnt_q, wait_cnt_d;
  logic                    end_pend_q, end_pend_d, err_pend_q, err_pend_d;
  logic                    busy_q, busy_d, done_q, err_q;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [OFFSET_WIDTH-1:0] ptr_q, ptr_d;
  logic                    inc_q, inc_d, srst_q, srst_d, exec_q, exec_d;

  logic [2:0]            opcode;
  logic [LOOP_WIDTH-1:0] arg;
  logic                  unused_bits;

  assign opcode      = bus.prog_data[OP_MSB:OP_LSB];
  assign arg         = bus.prog_data[LOOP_WIDTH-1:0];
  assign unused_bits = ^bus.prog_data[12:10];

  always_comb begin
    state_d       = state_q;
    prog_addr_d   = prog_addr_q;
    loop_start_d  = loop_start_q;
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    end_pend_d    = 1'b0;
    err_pend_d    = 1'b0;
    sel_d         = '0;
    ptr_d         = '0;
    inc_d         = 1'b0;
    srst_d        = 1'b0;
    exec_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // termination is still being reported this cycle; start waits for it
        if (bus.start && !end_pend_q && !err_pend_q) begin
          state_d       = ST_FETCH;
          prog_addr_d   = '0;
          loop_active_d = 1'b0;
          loop_cnt_d    = '0;
          wait_cnt_d    = '0;
        end
      end
      ST_FETCH, ST_BUBBLE: begin
        state_d     = ST_RUN;
        prog_addr_d = prog_addr_q + 1'b1;
      end
      ST_STALL: begin
        if (wait_cnt_q == LOOP_WIDTH'(1)) begin
          state_d     = ST_RUN;
          prog_addr_d = prog_addr_q + 1'b1;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        prog_addr_d = prog_addr_q + 1'b1;
        if (ir_pc_q == PC_LAST && opcode != OP_END) begin
          err_pend_d = 1'b1;
        end else begin
          case (opcode)
            OP_NOP: ;
            OP_EXEC: begin
              sel_d  = bus.prog_data[SEL_LSB +: SEL_WIDTH];
              ptr_d  = bus.prog_data[PTR_LSB +: OFFSET_WIDTH];
              inc_d  = bus.prog_data[INC_BIT];
              srst_d = bus.prog_data[SRST_BIT];
              exec_d = 1'b1;
            end
            OP_LOOP_BEGIN: begin
              if (loop_active_q) begin
                err_pend_d = 1'b1;
              end else begin
                loop_active_d = 1'b1;
                loop_cnt_d    = (arg == '0) ? LOOP_WIDTH'(1) : arg;
                loop_start_d  = ir_pc_q + 1'b1;
              end
            end
            OP_LOOP_END: begin
              if (!loop_active_q) begin
                err_pend_d = 1'b1;
              end else if (loop_cnt_q > LOOP_WIDTH'(1)) begin
                loop_cnt_d  = loop_cnt_q - 1'b1;
                prog_addr_d = loop_start_q;
                state_d     = ST_BUBBLE;
              end else begin
                loop_active_d = 1'b0;
                loop_cnt_d    = '0;
              end
            end
            OP_WAIT: begin
              // the WAIT cycle itself is the first idle cycle
              if (arg > LOOP_WIDTH'(1)) begin
                wait_cnt_d  = arg - 1'b1;
                prog_addr_d = prog_addr_q;
                state_d     = ST_STALL;
              end
            end
            OP_END:  end_pend_d = 1'b1;
            default: err_pend_d = 1'b1;
          endcase
        end
        if (end_pend_d || err_pend_d) begin
          state_d       = ST_IDLE;
          prog_addr_d   = '0;
          loop_active_d = 1'b0;
          loop_cnt_d    = '0;
          wait_cnt_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || end_pend_d || err_pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prog_addr_q   <= '0;
      ir_pc_q       <= '0;
      loop_start_q  <= '0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      end_pend_q    <= 1'b0;
      err_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      sel_q         <= '0;
      ptr_q         <= '0;
      inc_q         <= 1'b0;
      srst_q        <= 1'b0;
      exec_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_addr_q   <= prog_addr_d;
      ir_pc_q       <= prog_addr_q;
      loop_start_q  <= loop_start_d;
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      end_pend_q    <= end_pend_d;
      err_pend_q    <= err_pend_d;
      busy_q        <= busy_d;
      done_q        <= end_pend_q;
      err_q         <= err_pend_q;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      inc_q         <= inc_d;
      srst_q        <= srst_d;
      exec_q        <= exec_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.prog_addr  = prog_addr_q;
  assign bus.addr_sel   = sel_q;
  assign bus.addr_ptr   = ptr_q;
  assign bus.series_inc = inc_q;
  assign bus.series_rst = srst_q;

  pipeline_delay #(
    .WIDTH    (1),
    .CYCLES   (ADDR_LAT),
    .SHIFT_MEM(0)
  ) u_valid_dly (
    .clk (clk),
    .rst (rst),
    .din (exec_q),
    .dout(bus.addr_valid)
  );
endmodule
